// File: rtl/gc_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gc_scheduler
//
// Purpose:
//   Sequences garbage collection for the NVM block manager. Block numbers that
//   the remapping table reports as invalid are queued in a small FIFO. Once
//   the queue holds at least GC_THRESH entries, a GC window is requested from
//   the overall controller. When granted, one victim block at a time is moved
//   (valid pages relocated by the remap table) and then erased. The move
//   phase yields to host traffic by pausing and raising gc_interrupt. The
//   erase phase is not preemptible.
//
// Parameters:
//   BLK_W      width of a block number
//   FIFO_DEPTH invalid-block queue entries (power of two)
//   GC_THRESH  queue occupancy at or above which GC is requested (1..FIFO_DEPTH)
//   ERASE_CYC  cycles erase_en is held per erase (>= 1)
//
// Ports:
//   CLK            in   system clock
//   RST            in   synchronous active-high reset
//   invalid_flag   in   push invalid_blk into the queue this cycle
//   invalid_blk    in   block number that became invalid
//   gc_start       in   controller grants the GC window
//   active_request in   host access pending; preempts the move phase
//   move_done_flag in   remap table finished relocating active_blk
//   gc_request     out  GC window requested
//   gc_interrupt   out  GC paused for the host
//   request_done   out  one-cycle pulse when a victim is fully reclaimed
//   active_blk     out  victim block being relocated
//   move_flag      out  remap table is to relocate pages out of active_blk
//   erase_blk      out  block being erased
//   erase_en       out  erase strobe to the array
//   fifo_count     out  queue occupancy
//   overflow       out  sticky; a push was dropped because the queue was full
// ---------------------------------------------------------------------------
module gc_scheduler #(
  parameter int BLK_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int GC_THRESH  = 4,
  parameter int ERASE_CYC  = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          invalid_flag,
  input  logic [BLK_W-1:0]              invalid_blk,
  input  logic                          gc_start,
  input  logic                          active_request,
  input  logic                          move_done_flag,
  output logic                          gc_request,
  output logic                          gc_interrupt,
  output logic                          request_done,
  output logic [BLK_W-1:0]              active_blk,
  output logic                          move_flag,
  output logic [BLK_W-1:0]              erase_blk,
  output logic                          erase_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int ECNT_W = (ERASE_CYC > 1) ? $clog2(ERASE_CYC) : 1;

  localparam logic [CNT_W-1:0]  THRESH_C    = CNT_W'(GC_THRESH);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR    = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ECNT_W-1:0] ERASE_START = ECNT_W'(ERASE_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_ERASE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic [ECNT_W-1:0] erase_cnt;

  logic [BLK_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic fifo_full;
  logic pop;
  logic push_ok;

  // Pointer advance with explicit wrap so non-power-of-two depths still work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The only pop is the REQ->MOVE handoff; a push while full is accepted only
  // when that handoff frees a slot in the same cycle.
  always_comb begin
    fifo_full = (fifo_count == DEPTH_C);
    pop       = (state == S_REQ) && gc_start && !active_request;
    push_ok   = invalid_flag && (!fifo_full || pop);
  end

  // Queue storage has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= invalid_blk;
    end
  end

  // Queue bookkeeping. When full with a simultaneous push and pop, wr_ptr and
  // rd_ptr point at the same slot: the old head is read out this cycle while
  // the new entry replaces it, so the count stays at full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (invalid_flag && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // GC sequencing. active_blk is captured from the queue head at the pop, and
  // erase_blk is copied from active_blk when the move completes, so both stay
  // stable for the whole phase they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      active_blk <= '0;
      erase_blk  <= '0;
      erase_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_count >= THRESH_C) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (pop) begin
            active_blk <= mem[rd_ptr];
            state      <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (move_done_flag) begin
            erase_blk <= active_blk;
            erase_cnt <= ERASE_START;
            state     <= S_ERASE;
          end else if (active_request) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!active_request) begin
            state <= S_MOVE;
          end
        end
        S_ERASE: begin
          if (erase_cnt == '0) begin
            state <= S_DONE;
          end else begin
            erase_cnt <= erase_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are pure decodes of the registered state.
  always_comb begin
    gc_request   = 1'b0;
    gc_interrupt = 1'b0;
    request_done = 1'b0;
    move_flag    = 1'b0;
    erase_en     = 1'b0;
    case (state)
      S_REQ: begin
        gc_request = 1'b1;
      end
      S_MOVE: begin
        gc_request = 1'b1;
        move_flag  = 1'b1;
      end
      S_PAUSE: begin
        gc_request   = 1'b1;
        gc_interrupt = 1'b1;
      end
      S_ERASE: begin
        gc_request = 1'b1;
        erase_en   = 1'b1;
      end
      S_DONE: begin
        request_done = 1'b1;
      end
      default: begin
        gc_request = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gc_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_gc_scheduler
//
// Directed bench for gc_scheduler with the default parameters
// (BLK_W=8, FIFO_DEPTH=8, GC_THRESH=4, ERASE_CYC=16). Inputs change 1ns after
// a rising edge and outputs are sampled at the same point, i.e. each
// applyStimulus call covers exactly one rising edge.
// ---------------------------------------------------------------------------
module tb_gc_scheduler;

  logic       clk;
  logic       rst;
  logic       invalid_flag;
  logic [7:0] invalid_blk;
  logic       gc_start;
  logic       active_request;
  logic       move_done_flag;
  logic       gc_request;
  logic       gc_interrupt;
  logic       request_done;
  logic [7:0] active_blk;
  logic       move_flag;
  logic [7:0] erase_blk;
  logic       erase_en;
  logic [3:0] fifo_count;
  logic       overflow;

  int tests_run;
  int tests_failed;
  int n;

  gc_scheduler #(
    .BLK_W(8),
    .FIFO_DEPTH(8),
    .GC_THRESH(4),
    .ERASE_CYC(16)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .invalid_flag(invalid_flag),
    .invalid_blk(invalid_blk),
    .gc_start(gc_start),
    .active_request(active_request),
    .move_done_flag(move_done_flag),
    .gc_request(gc_request),
    .gc_interrupt(gc_interrupt),
    .request_done(request_done),
    .active_blk(active_blk),
    .move_flag(move_flag),
    .erase_blk(erase_blk),
    .erase_en(erase_en),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, let one rising edge pass, settle 1ns after it.
  task automatic applyStimulus(input logic f, input logic [7:0] b, input logic s,
                               input logic a, input logic m);
    invalid_flag   = f;
    invalid_blk    = b;
    gc_start       = s;
    active_request = a;
    move_done_flag = m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    idle();
    idle();

    // Reset state
    checkOutput("rst_gc_request", 32'(gc_request), 32'h0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    checkOutput("rst_active_blk", 32'(active_blk), 32'h0);
    checkOutput("rst_erase_en", 32'(erase_en), 32'h0);
    rst = 1'b0;

    // Fill to just below threshold, then reach it
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    checkOutput("below_thresh_count", 32'(fifo_count), 32'h3);
    checkOutput("below_thresh_req", 32'(gc_request), 32'h0);
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    checkOutput("at_thresh_count", 32'(fifo_count), 32'h4);
    checkOutput("at_thresh_req_still_idle", 32'(gc_request), 32'h0);
    idle();
    checkOutput("req_raised", 32'(gc_request), 32'h1);

    // Grant held off while the host is active
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("req_hold_req", 32'(gc_request), 32'h1);
    checkOutput("req_hold_move", 32'(move_flag), 32'h0);
    checkOutput("req_hold_count", 32'(fifo_count), 32'h4);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("move_active_blk", 32'(active_blk), 32'h05);
    checkOutput("move_flag_on", 32'(move_flag), 32'h1);
    checkOutput("move_pop_count", 32'(fifo_count), 32'h3);

    // Host preempts the move for 3 cycles; move_done_flag is ignored while paused
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("pause_interrupt", 32'(gc_interrupt), 32'h1);
    checkOutput("pause_move_off", 32'(move_flag), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("pause_ignores_done", 32'(erase_en), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("pause_still", 32'(gc_interrupt), 32'h1);
    idle();
    checkOutput("resume_move", 32'(move_flag), 32'h1);
    checkOutput("resume_no_int", 32'(gc_interrupt), 32'h0);
    checkOutput("resume_active_blk", 32'(active_blk), 32'h05);

    // Move completes: erase for exactly 16 cycles, then one done pulse
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("erase_en_on", 32'(erase_en), 32'h1);
    checkOutput("erase_blk", 32'(erase_blk), 32'h05);
    checkOutput("erase_move_off", 32'(move_flag), 32'h0);
    n = 0;
    while (erase_en === 1'b1 && n < 40) begin
      n++;
      idle();
    end
    checkOutput("erase_len", 32'(n), 32'd16);
    checkOutput("done_pulse", 32'(request_done), 32'h1);
    checkOutput("done_req_low", 32'(gc_request), 32'h0);
    idle();
    checkOutput("done_single", 32'(request_done), 32'h0);
    checkOutput("idle_below_thresh", 32'(gc_request), 32'h0);

    // Simultaneous move_done and host request: erase wins
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    checkOutput("refill_count", 32'(fifo_count), 32'h4);
    idle();
    checkOutput("req2_raised", 32'(gc_request), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("move2_active_blk", 32'(active_blk), 32'h06);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("prio_erase_en", 32'(erase_en), 32'h1);
    checkOutput("prio_no_int", 32'(gc_interrupt), 32'h0);
    checkOutput("prio_erase_blk", 32'(erase_blk), 32'h06);
    n = 0;
    while (request_done !== 1'b1 && n < 40) begin
      n++;
      idle();
    end
    checkOutput("prio_done_reached", 32'(request_done), 32'h1);
    idle();

    // Overflow: 9 pushes into an empty queue while GC is held off
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checkOutput("rst2_count", 32'(fifo_count), 32'h0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("full_count", 32'(fifo_count), 32'h8);
    checkOutput("full_overflow", 32'(overflow), 32'h1);
    checkOutput("full_req", 32'(gc_request), 32'h1);
    applyStimulus(1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
    checkOutput("full_pushpop_count", 32'(fifo_count), 32'h8);
    checkOutput("full_pop_head", 32'(active_blk), 32'h20);
    checkOutput("overflow_sticky", 32'(overflow), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("erase3_blk", 32'(erase_blk), 32'h20);
    n = 0;
    while (request_done !== 1'b1 && n < 40) begin
      n++;
      idle();
    end
    checkOutput("erase3_done_reached", 32'(request_done), 32'h1);
    idle();
    idle();
    checkOutput("req4_raised", 32'(gc_request), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("second_head", 32'(active_blk), 32'h21);
    checkOutput("second_pop_count", 32'(fifo_count), 32'h7);

    // Reset in the middle of an erase
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();
    idle();
    checkOutput("pre_rst_erase", 32'(erase_en), 32'h1);
    rst = 1'b1;
    idle();
    checkOutput("midrst_erase_en", 32'(erase_en), 32'h0);
    checkOutput("midrst_gc_request", 32'(gc_request), 32'h0);
    checkOutput("midrst_erase_blk", 32'(erase_blk), 32'h0);
    checkOutput("midrst_active_blk", 32'(active_blk), 32'h0);
    checkOutput("midrst_count", 32'(fifo_count), 32'h0);
    checkOutput("midrst_overflow", 32'(overflow), 32'h0);
    checkOutput("midrst_done", 32'(request_done), 32'h0);
    rst = 1'b0;
    idle();
    checkOutput("post_rst_idle", 32'(gc_request), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
